// File: rtl/ncl_pkg.sv
// Shared dual-rail (NCL) encoding constants, phase type and bit-level helpers
// for the pipelined NCL adder.
package ncl_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  typedef enum logic {PH_NULL, PH_DATA} phase_t;

  function automatic logic dr_is_data(input logic [1:0] x);
    return (x == DR_0) || (x == DR_1);
  endfunction

  function automatic logic dr_is_null(input logic [1:0] x);
    return x == DR_NULL;
  endfunction

  // Two cascaded half adders in minterm form; returns {carry[1:0], sum[1:0]}.
  // All-NULL inputs yield all-NULL outputs, so NULL wavefronts pass through.
  function automatic logic [3:0] dr_full_add(input logic [1:0] a, input logic [1:0] b,
                                             input logic [1:0] c);
    logic h_1, h_0, k1_1, k1_0, s_1, s_0, k2_1, k2_0;
    h_1  = (a[1] & b[0]) | (a[0] & b[1]);
    h_0  = (a[0] & b[0]) | (a[1] & b[1]);
    k1_1 = a[1] & b[1];
    k1_0 = (a[0] & b[0]) | (a[0] & b[1]) | (a[1] & b[0]);
    s_1  = (h_1 & c[0]) | (h_0 & c[1]);
    s_0  = (h_0 & c[0]) | (h_1 & c[1]);
    k2_1 = h_1 & c[1];
    k2_0 = (h_0 & c[0]) | (h_0 & c[1]) | (h_1 & c[0]);
    return {k1_1 | k2_1, k1_0 & k2_0, s_1, s_0};
  endfunction

endpackage

// File: rtl/ncl_add_stage.sv
// One NCL pipeline stage: adds a BPS-bit slice, registers the wavefront and
// drives ko. Bus layout (dual-rail bits): {carry, b_remaining, x}, where x holds
// finished sum bits below the slice and untouched A bits above it.
module ncl_add_stage
  import ncl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPS   = 2,
  parameter int REM   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [2*(WIDTH+REM+1)-1:0]       din,
  input  logic                             req,
  output logic                             ko,
  output logic [2*(WIDTH+REM-BPS+1)-1:0]   dout
);

  localparam int DONE    = WIDTH - REM;
  localparam int ROUT    = REM - BPS;
  localparam int IN_BITS = WIDTH + REM + 1;

  logic [2*WIDTH-1:0]  x_in, x_out;
  logic [2*REM-1:0]    b_in;
  logic [1:0]          c_in, c_out, carry;
  logic [3:0]          fa;
  logic                in_data, in_null;
  logic [$bits(dout)-1:0] nxt;
  phase_t              ph;

  assign x_in = din[2*WIDTH-1:0];
  assign b_in = din[2*WIDTH +: 2*REM];
  assign c_in = din[2*(WIDTH+REM) +: 2];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    in_data = 1'b1;
    in_null = 1'b1;
    for (int i = 0; i < IN_BITS; i++) begin
      in_data = in_data & dr_is_data(din[2*i +: 2]);
      in_null = in_null & dr_is_null(din[2*i +: 2]);
    end
  end

  always_comb begin
    x_out = x_in;
    carry = c_in;
    fa    = '0;
    for (int i = 0; i < BPS; i++) begin
      fa                       = dr_full_add(x_in[2*(DONE+i) +: 2], b_in[2*i +: 2], carry);
      x_out[2*(DONE+i) +: 2]   = fa[1:0];
      carry                    = fa[3:2];
    end
    c_out = carry;
  end

  if (ROUT > 0) begin : g_fwd_b
    assign nxt = {c_out, b_in[2*REM-1:2*BPS], x_out};
  end else begin : g_last
    assign nxt = {c_out, x_out};
  end

  // NOTE: state uses non-blocking assignments so all stages update from
  // pre-edge values; the data register is reset too because NULL content
  // must read as all-zero rails straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   <= PH_NULL;
      dout <= '0;
    end else if (ph == PH_NULL && req && in_data) begin
      ph   <= PH_DATA;
      dout <= nxt;
    end else if (ph == PH_DATA && !req && in_null) begin
      ph   <= PH_NULL;
      dout <= '0;
    end
  end

  assign ko = (ph == PH_NULL);

endmodule

// File: rtl/ncl_pipe_adder.sv
// Pipelined dual-rail NCL adder: STAGES clocked wavefront registers, each adding
// WIDTH/STAGES bits, plus a sticky illegal-code flag and a completed-word counter.
module ncl_pipe_adder
  import ncl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  input  logic [1:0]         cin,
  output logic               in_ko,
  output logic [2*WIDTH-1:0] sum,
  output logic [1:0]         cout,
  input  logic               out_ki,
  output logic               err,
  output logic [CNT_W-1:0]   word_count
);

  // WIDTH must be a multiple of STAGES.
  localparam int BPS = WIDTH / STAGES;

  // ko[k] is stage k's acknowledge; ko[STAGES] is the sink's request.
  logic [STAGES:0] ko;
  logic            in_ill, up_null, wc_inc;

  assign ko[STAGES] = out_ki;
  assign in_ko      = ko[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int REM = WIDTH - k * BPS;
    logic [2*(WIDTH+REM+1)-1:0]     din;
    logic [2*(WIDTH+REM-BPS+1)-1:0] dout;

    if (k == 0) begin : g_first
      assign din = {cin, b, a};
    end else begin : g_next
      assign din = g_st[k-1].dout;
    end

    ncl_add_stage #(
      .WIDTH (WIDTH),
      .BPS   (BPS),
      .REM   (REM)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .req   (ko[k+1]),
      .ko    (ko[k]),
      .dout  (dout)
    );
  end

  assign sum  = g_st[STAGES-1].dout[2*WIDTH-1:0];
  assign cout = g_st[STAGES-1].dout[2*WIDTH +: 2];

  always_comb begin
    in_ill = (cin == DR_ILL);
    for (int i = 0; i < WIDTH; i++)
      in_ill = in_ill | (a[2*i +: 2] == DR_ILL) | (b[2*i +: 2] == DR_ILL);
  end

  // A NULL register holds all-zero rails, so "upstream is complete-NULL" is
  // just the previous stage's ko; a single-stage pipe looks at the inputs.
  if (STAGES == 1) begin : g_up_in
    logic all_null;
    always_comb begin
      all_null = dr_is_null(cin);
      for (int i = 0; i < WIDTH; i++)
        all_null = all_null & dr_is_null(a[2*i +: 2]) & dr_is_null(b[2*i +: 2]);
    end
    assign up_null = all_null;
  end else begin : g_up_reg
    assign up_null = ko[STAGES-2];
  end

  assign wc_inc = !ko[STAGES-1] && !out_ki && up_null;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      if (in_ill) err <= 1'b1;
      if (wc_inc) word_count <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ncl_pipe_adder.sv
// Self-checking bench for ncl_pipe_adder: directed wavefront scenarios plus a
// randomized source/sink environment checked against plain-arithmetic sums.
module tb_ncl_pipe_adder;
  import ncl_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 4;
  localparam int CNT_W  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [2*WIDTH-1:0] a = '0, b = '0;
  logic [1:0]         cin = '0;
  logic               in_ko;
  logic [2*WIDTH-1:0] sum;
  logic [1:0]         cout;
  logic               out_ki = 1'b1;
  logic               err;
  logic [CNT_W-1:0]   word_count;

  ncl_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .in_ko      (in_ko),
    .sum        (sum),
    .cout       (cout),
    .out_ki     (out_ki),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
  } word_t;

  word_t      src_q[$];
  logic [8:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         rcv = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] enc1(input logic v);
    return v ? DR_1 : DR_0;
  endfunction

  function automatic logic [15:0] enc8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = enc1(v[i]);
    return r;
  endfunction

  function automatic logic [17:0] dr_word(input logic [8:0] r);
    return {enc1(r[8]), enc8(r[7:0])};
  endfunction

  function automatic logic [8:0] model(input word_t w);
    return {1'b0, w.a} + {1'b0, w.b} + {8'd0, w.c};
  endfunction

  function automatic bit out_is_data();
    logic [17:0] v;
    bit ok;
    v  = {cout, sum};
    ok = 1'b1;
    for (int i = 0; i < 9; i++) ok = ok & ((v[2*i +: 2] == DR_0) || (v[2*i +: 2] == DR_1));
    return ok;
  endfunction

  task automatic push(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    word_t w;
    w.a = av; w.b = bv; w.c = cv;
    src_q.push_back(w);
    exp_q.push_back(model(w));
  endtask

  // Source returns to NULL once a word is acknowledged; sink checks each word in
  // order and returns its request once the output has gone back to NULL.
  task automatic stream(input int hold_cyc, input bit rnd);
    bit   src_data = 1'b0;
    int   cyc = 0;
    int   toggles = 0;
    logic last_ko;
    last_ko = in_ko;
    forever begin
      @(negedge clk);
      if (hold_cyc > 0 && cyc >= hold_cyc - 2 && cyc < hold_cyc && in_ko !== last_ko) toggles++;
      if (hold_cyc > 0 && cyc == hold_cyc) begin
        check("bp_in_ko_stalled", toggles, 0);
        check("bp_out_frozen", {cout, sum}, dr_word(exp_q[0]));
      end
      last_ko = in_ko;
      if (src_data && !in_ko) begin
        a = '0; b = '0; cin = '0;
        src_data = 1'b0;
        void'(src_q.pop_front());
      end else if (!src_data && in_ko && src_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
        a = enc8(src_q[0].a); b = enc8(src_q[0].b); cin = enc1(src_q[0].c);
        src_data = 1'b1;
      end
      if (cyc >= hold_cyc && (!rnd || $urandom_range(0, 2) != 0)) begin
        if (out_ki && out_is_data()) begin
          check("word_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("stream_word", {cout, sum}, dr_word(exp_q.pop_front()));
          rcv++;
          out_ki = 1'b0;
        end else if (!out_ki && {cout, sum} == '0) begin
          check("word_count", word_count, rcv % (1 << CNT_W));
          out_ki = 1'b1;
        end
      end
      cyc++;
      if (src_q.size() == 0 && !src_data && exp_q.size() == 0 && out_ki
          && {cout, sum} == '0 && cyc > hold_cyc) break;
      if (cyc > 3000) begin
        check("stream_timeout_left", src_q.size() + exp_q.size(), 0);
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_in_ko", in_ko, 1);
    check("rst_sum", {cout, sum}, 0);
    check("rst_err", err, 0);
    check("rst_wc", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency of exactly STAGES edges, then NULL return and word count
    @(negedge clk);
    a = enc8(8'h5A); b = enc8(8'h3C); cin = DR_0; out_ki = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_not_early", out_is_data(), 0);
    @(negedge clk);
    check("lat_sum", {cout, sum}, dr_word(9'h096));
    check("lat_in_ko", in_ko, 0);
    a = '0; b = '0; cin = '0; out_ki = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("null_out", {cout, sum}, 0);
    check("null_wc", word_count, 1);
    rcv = 1;
    out_ki = 1'b1;

    // Carry ripple through all slices, then a zero word, in order
    push(8'hFF, 8'h01, 1'b1);
    push(8'h00, 8'h00, 1'b0);
    stream(0, 1'b0);

    // Random traffic with random source and sink delays
    for (int i = 0; i < 30; i++) push(8'($urandom), 8'($urandom), 1'($urandom));
    stream(0, 1'b1);

    // Incomplete wavefront is never captured
    @(negedge clk);
    a = enc8(8'h81); b = enc8(8'h7F); cin = DR_0;
    a[15:14] = DR_NULL;
    repeat (2) @(negedge clk);
    check("partial_no_capture", in_ko, 1);
    a[15:14] = DR_1;
    @(negedge clk);
    check("partial_captured", in_ko, 0);
    a = '0; b = '0; cin = '0;
    exp_q.push_back(9'h100);
    stream(0, 1'b1);

    // Illegal code sets sticky err and blocks capture
    @(negedge clk);
    a = enc8(8'h10); b = enc8(8'h22); cin = DR_1;
    b[7:6] = DR_ILL;
    repeat (2) @(negedge clk);
    check("ill_err", err, 1);
    check("ill_no_capture", in_ko, 1);
    b = enc8(8'h22);
    @(negedge clk);
    check("ill_fixed_captured", in_ko, 0);
    a = '0; b = '0; cin = '0;
    exp_q.push_back(9'h033);
    stream(0, 1'b1);
    check("ill_err_sticky", err, 1);

    // Asynchronous reset mid-stream, between clock edges
    @(negedge clk);
    a = enc8(8'h12); b = enc8(8'h34); cin = DR_0; out_ki = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("pre_reset_out", {cout, sum}, dr_word(9'h046));
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", {cout, sum}, 0);
    check("async_rst_in_ko", in_ko, 1);
    check("async_rst_err", err, 0);
    check("async_rst_wc", word_count, 0);
    a = '0; b = '0; cin = '0;
    rcv = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure: sink holds its request for 10 cycles, then drains; count wraps
    for (int i = 0; i < 5; i++) push(8'($urandom), 8'($urandom), 1'($urandom));
    stream(10, 1'b0);
    check("wrap_wc", word_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
